if_id_buf: RTL

- Decoupling buffer between the instruction-fetch stage and the decode stage.
- Captures {pc, instr, pc_misalign, bus_err} from fetch with a valid/ready handshake and presents them in order to decode.
- Absorbs decode stalls, supports pipeline flush on redirect/trap, and fences fetch after a fetch exception.

---
 rtl/if_id_buf_pkg.sv | 56 +++++
 rtl/if_id_buf_mem.sv | 36 +++
 rtl/if_id_buf.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/if_id_buf_pkg.sv
// if_id_buf_pkg: shared widths, entry layout and state encoding for the
// fetch/decode decoupling buffer.
//
// The global macros `PC_WIDTH, `INSTR_WIDTH and `XLEN come from the
// project defines. `INSTR_NOP and `IF_ID_ENT_W are added next to them here.
// Every macro is guarded, so a build that already defines them keeps its own values.
// The other files use only the localparams below, never the macros directly.
//
// Optional feature macro: IF_ID_BYPASS_EN (used in if_id_buf.sv).

`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h00000013
`endif
`ifndef IF_ID_ENT_W
`define IF_ID_ENT_W (`PC_WIDTH+`INSTR_WIDTH+2)
`endif

package if_id_buf_pkg;

  localparam int unsigned PcW    = `PC_WIDTH;
  localparam int unsigned InstrW = `INSTR_WIDTH;
  localparam int unsigned EntW   = `IF_ID_ENT_W;

  // addi x0, x0, 0
  localparam logic [InstrW-1:0] InstrNop = `INSTR_NOP;

  localparam logic StateAccept = 1'b0;
  localparam logic StateFenced = 1'b1;

  typedef enum logic {
    StAccept = StateAccept,
    StFenced = StateFenced
  } state_e;

  // Field order fixes the packed layout stored in if_id_buf_mem.
  typedef struct packed {
    logic [PcW-1:0]    pc;
    logic [InstrW-1:0] instr;
    logic              pc_misalign;
    logic              bus_err;
  } if_id_ent_t;

  function automatic logic ent_is_exc(if_id_ent_t ent);
    return ent.pc_misalign | ent.bus_err;
  endfunction

endpackage

// File: rtl/if_id_buf_mem.sv
// if_id_buf_mem: Depth x Width register array. It has one synchronous write
// port and one asynchronous (combinational) read port. The storage has no reset.
// Contents are only meaningful where the owner's occupancy count says so.
//
// Ports:
//   clk_i    clock
//   we_i     write enable, the write takes effect on the rising edge
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, combinational from raddr_i

module if_id_buf_mem #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 66,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_buf.sv
// if_id_buf: in-order decoupling buffer between instruction fetch and decode.
// It captures {pc, instr, pc_misalign, bus_err} with a valid/ready handshake.
// It absorbs decode stalls and flushes on redirect/trap. After a push that
// carries a fetch exception it fences fetch (FENCED state) until flush.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   if_valid_i/if_ready_o  fetch handshake; ready depends only on registered state
//   if_pc_i, if_instr_i    fetched entry
//   if_pc_misalign_i       fetch address misaligned
//   if_bus_err_i           fetch bus error
//   id_valid_o/id_ready_i  decode handshake
//   id_pc_o, id_instr_o    head entry (NOP/0 when empty)
//   id_pc_misalign_o       head misalign flag
//   id_bus_err_o           head bus-error flag
//   flush_i                discard contents, return to ACCEPT
//   fenced_o               buffer is fenced
//   count_o                occupancy
//
// Optional feature macro: IF_ID_BYPASS_EN. When it is defined and the buffer
// is empty, in ACCEPT and not flushing, fetch data flows combinationally to
// decode. If decode takes the entry in that cycle, nothing is written.

module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [PcW-1:0]    if_pc_i,
  input  logic [InstrW-1:0] if_instr_i,
  input  logic              if_pc_misalign_i,
  input  logic              if_bus_err_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [PcW-1:0]    id_pc_o,
  output logic [InstrW-1:0] id_instr_o,
  output logic              id_pc_misalign_o,
  output logic              id_bus_err_o,
  input  logic              flush_i,
  output logic              fenced_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;

  if_id_ent_t      in_ent;
  if_id_ent_t      head_ent;
  logic [EntW-1:0] rd_raw;

  logic empty;
  logic push;
  logic pop;
  logic byp_act;
  logic wr_en;
  logic rd_en;

  assign in_ent = '{
    pc:          if_pc_i,
    instr:       if_instr_i,
    pc_misalign: if_pc_misalign_i,
    bus_err:     if_bus_err_i
  };

  if_id_buf_mem #(
    .Depth (DEPTH),
    .Width (EntW),
    .AddrW (PtrW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (in_ent),
    .raddr_i (rptr_q),
    .rdata_o (rd_raw)
  );

  assign head_ent = if_id_ent_t'(rd_raw);

  // Handshake and head presentation.
  always_comb begin
    empty      = (cnt_q == '0);
    if_ready_o = (state_q == StAccept) && (cnt_q < CNT_W'(DEPTH));
    push       = if_valid_i & if_ready_o;

    byp_act = 1'b0;
`ifdef IF_ID_BYPASS_EN
    byp_act = empty & (state_q == StAccept) & ~flush_i;
`endif

    id_valid_o       = 1'b0;
    id_pc_o          = '0;
    id_instr_o       = InstrNop;
    id_pc_misalign_o = 1'b0;
    id_bus_err_o     = 1'b0;

    if (byp_act) begin
      id_valid_o = if_valid_i;
      if (if_valid_i) begin
        id_pc_o          = in_ent.pc;
        id_instr_o       = in_ent.instr;
        id_pc_misalign_o = in_ent.pc_misalign;
        id_bus_err_o     = in_ent.bus_err;
      end
    end else if (!empty) begin
      // Flush hides the head from decode in the same cycle.
      id_valid_o       = ~flush_i;
      id_pc_o          = head_ent.pc;
      id_instr_o       = head_ent.instr;
      id_pc_misalign_o = head_ent.pc_misalign;
      id_bus_err_o     = head_ent.bus_err;
    end

    pop = id_valid_o & id_ready_i;

    // A bypassed entry that decode takes at once is never written.
    // A pop in bypass mode consumes the bypassed entry, not storage.
    wr_en = push & ~(byp_act & pop) & ~flush_i;
    rd_en = pop & ~byp_act;
  end

  // Next-state: flush wins over push and pop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;

    if (flush_i) begin
      state_d = StAccept;
      cnt_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (wr_en) begin
        wptr_d = wptr_q + PtrW'(1);
      end
      if (rd_en) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      if (push && ent_is_exc(in_ent)) begin
        state_d = StFenced;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StAccept;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  assign fenced_o = (state_q == StFenced);
  assign count_o  = cnt_q;

endmodule
